aes256_key_schedule: RTL and testbench

- Sequential AES-256 key schedule. Consumes the combinational keyExpansion256 step and drives it for 7 iterations, one per clock.
- Stores all 15 round keys (128 bits each) in an internal register file.
- Serves the stored keys to the downstream round datapath through an indexed read port with 1-cycle latency.
- Sits between the key-load interface and the cipher rounds.

---
 rtl/aes256_key_schedule.sv | 149 ++++++++++++++
 tb/tb_aes256_key_schedule.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_schedule.sv
// rtl/aes256_key_schedule.sv - sequential AES-256 key schedule with indexed round-key read port (optional AES256_KS_ZEROIZE_EN)
module aes256_key_schedule #(
  parameter int NUM_RK = 15,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [255:0]     key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [127:0]     rk_out
`ifdef AES256_KS_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} stateType;

  stateType     state;
  logic [255:0] work;
  logic [31:0]  rcon;
  logic [2:0]   iter;
  logic [127:0] rk [NUM_RK];
  logic [255:0] nxt;
  logic [IDX_W-1:0] hiIdx;
  logic [IDX_W-1:0] loIdx;
  logic         zeroizeReq;

`ifdef AES256_KS_ZEROIZE_EN
  assign zeroizeReq = zeroize;
`else
  assign zeroizeReq = 1'b0;
`endif

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as a^254 (field inverse, 0 maps to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-256 expansion step: eight input words produce the next eight
  function automatic logic [255:0] keyExpansion256(input logic [255:0] k, input logic [31:0] rc);
    logic [31:0] w [16];
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    w[8]  = w[0] ^ subWord({w[7][23:0], w[7][31:24]}) ^ rc;
    w[9]  = w[1] ^ w[8];
    w[10] = w[2] ^ w[9];
    w[11] = w[3] ^ w[10];
    w[12] = w[4] ^ subWord(w[11]);
    w[13] = w[5] ^ w[12];
    w[14] = w[6] ^ w[13];
    w[15] = w[7] ^ w[14];
    return {w[8], w[9], w[10], w[11], w[12], w[13], w[14], w[15]};
  endfunction

  assign nxt   = keyExpansion256(work, rcon);
  assign hiIdx = IDX_W'({iter, 1'b0}) + IDX_W'(2);
  assign loIdx = hiIdx + IDX_W'(1);

  // Control FSM, working key and round-key register file
  always_ff @(posedge clk) begin
    if (reset || zeroizeReq) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      work       <= '0;
      rcon       <= 32'h01000000;
      iter       <= '0;
      for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work       <= key_in;
            rk[0]      <= key_in[255:128];
            rk[1]      <= key_in[127:0];
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            iter       <= '0;
            rcon       <= 32'h01000000;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          work      <= nxt;
          rk[hiIdx] <= nxt[255:128];
          // the final step only contributes the upper half (rk[14])
          if (iter != 3'd6) rk[loIdx] <= nxt[127:0];
          rcon <= {rcon[30:24], 1'b0, 24'h000000};
          iter <= iter + 3'd1;
          if (iter == 3'd6) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port, live in every state; out-of-range index reads zero
  always_ff @(posedge clk) begin
    if (reset || zeroizeReq) begin
      rk_out <= '0;
    end else if (int'(rk_idx) < NUM_RK) begin
      rk_out <= rk[rk_idx];
    end else begin
      rk_out <= '0;
    end
  end

endmodule

// File: tb/tb_aes256_key_schedule.sv
// tb/tb_aes256_key_schedule.sv - directed self-checking bench for aes256_key_schedule
module tb_aes256_key_schedule;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] ZK_RK2 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZK_RK3 = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef AES256_KS_ZEROIZE_EN
  logic         zeroize;
`endif

  int checks   = 0;
  int failures = 0;
  logic [127:0] fipsRk [16];

  aes256_key_schedule dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
`ifdef AES256_KS_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic startKey(input logic [255:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic readRk(input int idx, output logic [127:0] v);
    @(negedge clk);
    rk_idx = 4'(idx);
    @(negedge clk);
    v = rk_out;
  endtask

  initial begin
    int cyc;
    int doneCount;
    logic [127:0] v;

    fipsRk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fipsRk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    fipsRk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    fipsRk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    fipsRk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    fipsRk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    fipsRk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    fipsRk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    fipsRk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    fipsRk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    fipsRk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    fipsRk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    fipsRk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    fipsRk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    fipsRk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    fipsRk[15] = 128'h0;

    reset  = 1'b1;
    start  = 1'b0;
    key_in = '0;
    rk_idx = '0;
`ifdef AES256_KS_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(keys_valid), 128'(0));
    chk("rst_rkout", rk_out, 128'h0);
    reset = 1'b0;
    readRk(5, v);
    chk("rst_rk5", v, 128'h0);

    // FIPS key: latency, flags, full read sweep
    startKey(FIPS_KEY);
    chk("t1_busy_load", 128'(busy), 128'(1));
    chk("t1_valid_load", 128'(keys_valid), 128'(0));
    waitDone(cyc);
    chk("t1_latency", 128'(cyc), 128'(8));
    chk("t1_busy_done", 128'(busy), 128'(1));
    @(negedge clk);
    chk("t1_done_pulse", 128'(done), 128'(0));
    chk("t1_busy_end", 128'(busy), 128'(0));
    chk("t1_valid_end", 128'(keys_valid), 128'(1));
    for (int i = 0; i < 16; i++) begin
      readRk(i, v);
      chk($sformatf("t1_rk%0d", i), v, fipsRk[i]);
    end

    // start during EXPAND with a different key is ignored
    startKey(FIPS_KEY);
    @(negedge clk);
    key_in = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    chk("t2_done_count", 128'(doneCount), 128'(1));
    chk("t2_valid", 128'(keys_valid), 128'(1));
    chk("t2_busy", 128'(busy), 128'(0));
    readRk(0, v);
    chk("t2_rk0", v, fipsRk[0]);
    readRk(2, v);
    chk("t2_rk2", v, fipsRk[2]);
    readRk(14, v);
    chk("t2_rk14", v, fipsRk[14]);

    // reset in the 4th EXPAND cycle, then a fresh schedule
    startKey(FIPS_KEY);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t3_busy", 128'(busy), 128'(0));
    chk("t3_valid", 128'(keys_valid), 128'(0));
    chk("t3_rkout", rk_out, 128'h0);
    chk("t3_done", 128'(done), 128'(0));
    reset = 1'b0;
    readRk(2, v);
    chk("t3_rk2_cleared", v, 128'h0);
    startKey(FIPS_KEY);
    waitDone(cyc);
    chk("t3_latency", 128'(cyc), 128'(8));
    @(negedge clk);
    readRk(14, v);
    chk("t3_rk14", v, fipsRk[14]);
    readRk(1, v);
    chk("t3_rk1", v, fipsRk[1]);

    // back-to-back: zero key, then FIPS key
    chk("t4_valid_before", 128'(keys_valid), 128'(1));
    startKey('0);
    chk("t4_valid_fall1", 128'(keys_valid), 128'(0));
    waitDone(cyc);
    chk("t4_latency_zero", 128'(cyc), 128'(8));
    @(negedge clk);
    chk("t4_valid_zero", 128'(keys_valid), 128'(1));
    readRk(0, v);
    chk("t4_zk_rk0", v, 128'h0);
    readRk(2, v);
    chk("t4_zk_rk2", v, ZK_RK2);
    readRk(3, v);
    chk("t4_zk_rk3", v, ZK_RK3);
    startKey(FIPS_KEY);
    chk("t4_valid_fall2", 128'(keys_valid), 128'(0));
    waitDone(cyc);
    chk("t4_latency_fips", 128'(cyc), 128'(8));
    @(negedge clk);
    readRk(14, v);
    chk("t4_rk14", v, fipsRk[14]);

`ifdef AES256_KS_ZEROIZE_EN
    // zeroize together with start wipes keys and does not launch a schedule
    @(negedge clk);
    rk_idx  = 4'd14;
    key_in  = FIPS_KEY;
    start   = 1'b1;
    zeroize = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    zeroize = 1'b0;
    chk("t5_valid", 128'(keys_valid), 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_rkout", rk_out, 128'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_idle%0d", i), 128'({busy, done}), 128'(0));
    end
    readRk(14, v);
    chk("t5_rk14", v, 128'h0);
    readRk(0, v);
    chk("t5_rk0", v, 128'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
